// File: rtl/decode_pkg.sv
// Shared encodings for the ID stage: opcodes, ALU/immediate/result select codes,
// the decoded control bundle and the skid-buffer state type.
package decode_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;

    localparam logic [4:0] ALU_ADD       = 5'd0;
    localparam logic [4:0] ALU_SUB       = 5'd1;
    localparam logic [4:0] ALU_AND       = 5'd2;
    localparam logic [4:0] ALU_OR        = 5'd3;
    localparam logic [4:0] ALU_SLT       = 5'd4;
    localparam logic [4:0] ALU_XOR       = 5'd5;
    localparam logic [4:0] ALU_SH1ADD    = 5'd8;
    localparam logic [4:0] ALU_SH2ADD    = 5'd9;
    localparam logic [4:0] ALU_SH3ADD    = 5'd10;
    localparam logic [4:0] ALU_ADD_UW    = 5'd11;
    localparam logic [4:0] ALU_SH1ADD_UW = 5'd12;
    localparam logic [4:0] ALU_SH2ADD_UW = 5'd13;
    localparam logic [4:0] ALU_SH3ADD_UW = 5'd14;
    localparam logic [4:0] ALU_SLLI_UW   = 5'd15;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    // wd3_src marks link-register writes (JAL/JALR), where the write data is PC+4.
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       wd3_src;
        logic       word_op;
        logic       illegal;
        logic [1:0] result_src;
        logic [2:0] imm_src;
        logic [4:0] alu_control;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = ctrl_t'(18'h0);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } buf_state_t;

endpackage

// File: rtl/decode_comb.sv
// Pure combinational RV32/RV64 + Zba decoder: raw instruction to control bundle.
// Anything not explicitly recognised comes out as illegal with all controls cleared.
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ZBA_EN = 1
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl
);

    localparam logic RV64_L = (XLEN == 64);
    localparam logic ZBA_L  = (ZBA_EN != 0);

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [6:0] funct7_s;
    logic       legal_s;
    ctrl_t      fields_s;
    logic       unused_s;

    assign opcode_s = instr[6:0];
    assign funct3_s = instr[14:12];
    assign funct7_s = instr[31:25];
    assign unused_s = ^{instr[24:15], instr[11:7]};

    // Field decode per opcode, then mask everything if the encoding is not legal.
    always_comb begin
        fields_s = CTRL_NONE;
        legal_s  = 1'b0;
        case (opcode_s)
            OPC_LOAD: begin
                fields_s.reg_write  = 1'b1;
                fields_s.alu_src    = 1'b1;
                fields_s.result_src = RES_MEM;
                fields_s.imm_src    = IMM_I;
                case (funct3_s)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_s = 1'b1;
                    3'b011, 3'b110:                         legal_s = RV64_L;
                    default:                                legal_s = 1'b0;
                endcase
            end
            OPC_STORE: begin
                fields_s.mem_write = 1'b1;
                fields_s.alu_src   = 1'b1;
                fields_s.imm_src   = IMM_S;
                case (funct3_s)
                    3'b000, 3'b001, 3'b010: legal_s = 1'b1;
                    3'b011:                 legal_s = RV64_L;
                    default:                legal_s = 1'b0;
                endcase
            end
            OPC_OP: begin
                fields_s.reg_write = 1'b1;
                case ({funct7_s, funct3_s})
                    {7'b0000000, 3'b000}: begin fields_s.alu_control = ALU_ADD;    legal_s = 1'b1;  end
                    {7'b0100000, 3'b000}: begin fields_s.alu_control = ALU_SUB;    legal_s = 1'b1;  end
                    {7'b0000000, 3'b111}: begin fields_s.alu_control = ALU_AND;    legal_s = 1'b1;  end
                    {7'b0000000, 3'b110}: begin fields_s.alu_control = ALU_OR;     legal_s = 1'b1;  end
                    {7'b0000000, 3'b010}: begin fields_s.alu_control = ALU_SLT;    legal_s = 1'b1;  end
                    {7'b0000000, 3'b100}: begin fields_s.alu_control = ALU_XOR;    legal_s = 1'b1;  end
                    {7'b0010000, 3'b010}: begin fields_s.alu_control = ALU_SH1ADD; legal_s = ZBA_L; end
                    {7'b0010000, 3'b100}: begin fields_s.alu_control = ALU_SH2ADD; legal_s = ZBA_L; end
                    {7'b0010000, 3'b110}: begin fields_s.alu_control = ALU_SH3ADD; legal_s = ZBA_L; end
                    default:              begin fields_s.alu_control = ALU_ADD;    legal_s = 1'b0;  end
                endcase
            end
            OPC_OP_IMM: begin
                fields_s.reg_write = 1'b1;
                fields_s.alu_src   = 1'b1;
                fields_s.imm_src   = IMM_I;
                legal_s            = 1'b1;
                case (funct3_s)
                    3'b000:  fields_s.alu_control = ALU_ADD;
                    3'b010:  fields_s.alu_control = ALU_SLT;
                    3'b100:  fields_s.alu_control = ALU_XOR;
                    3'b110:  fields_s.alu_control = ALU_OR;
                    3'b111:  fields_s.alu_control = ALU_AND;
                    default: legal_s = 1'b0;
                endcase
            end
            OPC_OP_32: begin
                fields_s.reg_write = 1'b1;
                case ({funct7_s, funct3_s})
                    {7'b0000000, 3'b000}: begin
                        fields_s.alu_control = ALU_ADD;
                        fields_s.word_op     = 1'b1;
                        legal_s              = RV64_L;
                    end
                    {7'b0100000, 3'b000}: begin
                        fields_s.alu_control = ALU_SUB;
                        fields_s.word_op     = 1'b1;
                        legal_s              = RV64_L;
                    end
                    {7'b0000100, 3'b000}: begin fields_s.alu_control = ALU_ADD_UW;    legal_s = RV64_L & ZBA_L; end
                    {7'b0010000, 3'b010}: begin fields_s.alu_control = ALU_SH1ADD_UW; legal_s = RV64_L & ZBA_L; end
                    {7'b0010000, 3'b100}: begin fields_s.alu_control = ALU_SH2ADD_UW; legal_s = RV64_L & ZBA_L; end
                    {7'b0010000, 3'b110}: begin fields_s.alu_control = ALU_SH3ADD_UW; legal_s = RV64_L & ZBA_L; end
                    default:              begin fields_s.alu_control = ALU_ADD;       legal_s = 1'b0;           end
                endcase
            end
            OPC_OP_IMM_32: begin
                fields_s.reg_write = 1'b1;
                fields_s.alu_src   = 1'b1;
                fields_s.imm_src   = IMM_I;
                if (funct3_s == 3'b000) begin
                    fields_s.word_op = 1'b1;
                    legal_s          = RV64_L;
                end else if ((funct3_s == 3'b001) && (instr[31:26] == 6'b000010)) begin
                    fields_s.alu_control = ALU_SLLI_UW;
                    legal_s              = RV64_L & ZBA_L;
                end else begin
                    legal_s = 1'b0;
                end
            end
            OPC_BRANCH: begin
                fields_s.branch      = 1'b1;
                fields_s.imm_src     = IMM_B;
                fields_s.alu_control = ALU_SUB;
                legal_s              = (funct3_s != 3'b010) && (funct3_s != 3'b011);
            end
            OPC_JAL: begin
                fields_s.reg_write  = 1'b1;
                fields_s.jump       = 1'b1;
                fields_s.wd3_src    = 1'b1;
                fields_s.result_src = RES_PC4;
                fields_s.imm_src    = IMM_J;
                legal_s             = 1'b1;
            end
            OPC_JALR: begin
                fields_s.reg_write  = 1'b1;
                fields_s.jump       = 1'b1;
                fields_s.wd3_src    = 1'b1;
                fields_s.alu_src    = 1'b1;
                fields_s.result_src = RES_PC4;
                fields_s.imm_src    = IMM_I;
                legal_s             = (funct3_s == 3'b000);
            end
            OPC_LUI: begin
                fields_s.reg_write  = 1'b1;
                fields_s.result_src = RES_IMM;
                fields_s.imm_src    = IMM_U;
                legal_s             = 1'b1;
            end
            default: begin
                fields_s = CTRL_NONE;
                legal_s  = 1'b0;
            end
        endcase

        if (legal_s) begin
            ctrl = fields_s;
        end else begin
            ctrl         = CTRL_NONE;
            ctrl.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered ID stage: decodes on entry and holds up to two entries (output
// register plus skid) behind a valid/ready handshake with a registered in_ready.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ZBA_EN = 1,
    parameter int ALUC_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [31:0]       out_instr,
    output logic              reg_write,
    output logic              mem_write,
    output logic              alu_src,
    output logic              branch,
    output logic              jump,
    output logic              wd3_src,
    output logic              word_op,
    output logic              illegal,
    output logic [1:0]        result_src,
    output logic [2:0]        imm_src,
    output logic [ALUC_W-1:0] alu_control
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        ctrl_t           ctrl;
    } entry_t;

    ctrl_t      dec_s;
    entry_t     in_entry_s;
    entry_t     out_r;
    entry_t     skid_r;
    buf_state_t state_r;
    buf_state_t state_nx_s;
    logic       out_valid_r;
    logic       in_ready_r;
    logic       out_valid_nx_s;
    logic       in_ready_nx_s;
    logic       accept_s;
    logic       pop_s;
    logic       load_out_in_s;
    logic       load_out_skid_s;
    logic       load_skid_s;

    decode_comb #(
        .XLEN   (XLEN),
        .ZBA_EN (ZBA_EN)
    ) u_decode_comb (
        .instr (in_instr),
        .ctrl  (dec_s)
    );

    assign in_entry_s = {in_pc, in_instr, dec_s};
    assign accept_s   = in_valid & in_ready_r;
    assign pop_s      = out_valid_r & out_ready;

    // Buffer state and the registered handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_nx_s;
            out_valid_r <= out_valid_nx_s;
            in_ready_r  <= in_ready_nx_s;
        end
    end

    // Next buffer occupancy; flush empties the buffer whatever else happens.
    always_comb begin
        state_nx_s = state_r;
        if (flush) begin
            state_nx_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: state_nx_s = accept_s ? ST_ONE : ST_EMPTY;
                ST_ONE: begin
                    if (accept_s && !pop_s) begin
                        state_nx_s = ST_TWO;
                    end else if (pop_s && !accept_s) begin
                        state_nx_s = ST_EMPTY;
                    end else begin
                        state_nx_s = ST_ONE;
                    end
                end
                ST_TWO:   state_nx_s = pop_s ? ST_ONE : ST_TWO;
                default:  state_nx_s = ST_EMPTY;
            endcase
        end
    end

    // Next handshake flags and payload-register load enables.
    always_comb begin
        out_valid_nx_s  = (state_nx_s != ST_EMPTY);
        in_ready_nx_s   = (state_nx_s != ST_TWO);
        load_out_in_s   = 1'b0;
        load_out_skid_s = 1'b0;
        load_skid_s     = 1'b0;
        if (flush) begin
            load_out_in_s = 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: load_out_in_s = accept_s;
                ST_ONE: begin
                    load_out_in_s = accept_s & pop_s;
                    load_skid_s   = accept_s & ~pop_s;
                end
                ST_TWO:   load_out_skid_s = pop_s;
                default:  load_out_in_s   = 1'b0;
            endcase
        end
    end

    // Payload registers; cleared on reset and flush so a dropped entry leaves no residue.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_r  <= '0;
            skid_r <= '0;
        end else begin
            if (load_out_in_s) begin
                out_r <= in_entry_s;
            end else if (load_out_skid_s) begin
                out_r <= skid_r;
            end else begin
                out_r <= out_r;
            end
            if (load_skid_s) begin
                skid_r <= in_entry_s;
            end else begin
                skid_r <= skid_r;
            end
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_pc      = out_r.pc;
    assign out_instr   = out_r.instr;
    assign reg_write   = out_r.ctrl.reg_write;
    assign mem_write   = out_r.ctrl.mem_write;
    assign alu_src     = out_r.ctrl.alu_src;
    assign branch      = out_r.ctrl.branch;
    assign jump        = out_r.ctrl.jump;
    assign wd3_src     = out_r.ctrl.wd3_src;
    assign word_op     = out_r.ctrl.word_op;
    assign illegal     = out_r.ctrl.illegal;
    assign result_src  = out_r.ctrl.result_src;
    assign imm_src     = out_r.ctrl.imm_src;
    assign alu_control = ALUC_W'(out_r.ctrl.alu_control);

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: an RV64/Zba instance and an RV32/no-Zba instance fed in lockstep,
// table-driven decode vectors plus hand sequences for skid, flush and reset behaviour.
module tb_decode_stage;

    typedef struct {
        logic [31:0] instr;
        logic [17:0] exp;
        logic        ill_n;
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [17:0] exp;
        logic        ill_n;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = 32'h0;
    logic [63:0] in_pc = 64'h0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, reg_write, mem_write, alu_src, branch, jump, wd3_src, word_op, illegal;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [1:0]  result_src;
    logic [2:0]  imm_src;
    logic [4:0]  alu_control;

    logic        in_ready_n, out_valid_n, reg_write_n, mem_write_n, alu_src_n, branch_n, jump_n;
    logic        wd3_src_n, word_op_n, illegal_n;
    logic [31:0] out_pc_n;
    logic [31:0] out_instr_n;
    logic [1:0]  result_src_n;
    logic [2:0]  imm_src_n;
    logic [5:0]  alu_control_n;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          popped;
    logic [17:0] cur_exp;
    logic        cur_ill_n;
    sb_t         sb[$];
    vec_t        vecs[31];

    always #5 clk = ~clk;

    decode_stage #(.XLEN(64), .ZBA_EN(1), .ALUC_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .reg_write(reg_write), .mem_write(mem_write),
        .alu_src(alu_src), .branch(branch), .jump(jump), .wd3_src(wd3_src), .word_op(word_op),
        .illegal(illegal), .result_src(result_src), .imm_src(imm_src), .alu_control(alu_control)
    );

    decode_stage #(.XLEN(32), .ZBA_EN(0), .ALUC_W(6)) dut_n (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_n),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(out_valid_n), .out_ready(out_ready),
        .out_pc(out_pc_n), .out_instr(out_instr_n), .reg_write(reg_write_n), .mem_write(mem_write_n),
        .alu_src(alu_src_n), .branch(branch_n), .jump(jump_n), .wd3_src(wd3_src_n), .word_op(word_op_n),
        .illegal(illegal_n), .result_src(result_src_n), .imm_src(imm_src_n), .alu_control(alu_control_n)
    );

    // flags order: reg_write mem_write alu_src branch jump wd3_src word_op illegal
    function automatic logic [17:0] mk(input logic [7:0] flags, input logic [1:0] rs,
                                       input logic [2:0] is, input logic [4:0] ac);
        return {flags, rs, is, ac};
    endfunction

    function automatic logic [17:0] act_w();
        return {reg_write, mem_write, alu_src, branch, jump, wd3_src, word_op, illegal,
                result_src, imm_src, alu_control};
    endfunction

    function automatic logic [18:0] act_n();
        return {reg_write_n, mem_write_n, alu_src_n, branch_n, jump_n, wd3_src_n, word_op_n, illegal_n,
                result_src_n, imm_src_n, alu_control_n};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic [31:0] instr, input logic [17:0] exp, input logic ill_n,
                          input logic [63:0] pc);
        in_instr  = instr;
        in_pc     = pc;
        cur_exp   = exp;
        cur_ill_n = ill_n;
    endtask

    // One clock: score the handshake seen before the edge, then advance to just after it.
    task automatic tick();
        bit  acc;
        bit  pp;
        sb_t e;
        logic [18:0] exp_n;
        acc = in_valid && in_ready;
        pp  = out_valid && out_ready;
        if (pp) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                exp_n = e.ill_n ? 19'h00800 : {e.exp[17:5], 1'b0, e.exp[4:0]};
                chk($sformatf("ctrl_%h", e.instr), act_w(), e.exp);
                chk($sformatf("pc_%h", e.instr), out_pc, e.pc);
                chk($sformatf("instr_%h", e.instr), out_instr, e.instr);
                chk($sformatf("ctrl_rv32_%h", e.instr), act_n(), exp_n);
                chk($sformatf("pc_rv32_%h", e.instr), out_pc_n, e.pc[31:0]);
                chk($sformatf("instr_rv32_%h", e.instr), out_instr_n, e.instr);
                chk("valid_rv32", out_valid_n, 1'b1);
            end
        end
        if (acc && !flush && !rst) begin
            sb.push_back('{pc: in_pc, instr: in_instr, exp: cur_exp, ill_n: cur_ill_n});
        end
        if (flush || rst) begin
            sb.delete();
        end
        popped = pp;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            tick();
        end
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    task automatic check_cleared(input string name);
        chk({name, "_valid"}, out_valid, 1'b0);
        chk({name, "_ready"}, in_ready, 1'b1);
        chk({name, "_ctrl"}, act_w(), 18'h0);
        chk({name, "_pc"}, out_pc, 64'h0);
        chk({name, "_instr"}, out_instr, 32'h0);
        chk({name, "_valid_rv32"}, out_valid_n, 1'b0);
        chk({name, "_ready_rv32"}, in_ready_n, 1'b1);
    endtask

    localparam logic [17:0] ILL = 18'h00400;

    initial begin
        logic [17:0] addi_exp;
        logic [17:0] lui_exp;
        int          n_acc;
        int          n_pop;
        int          last_pop;
        bit          acc;

        addi_exp = mk(8'b1010_0000, 2'b00, 3'b000, 5'd0);
        lui_exp  = mk(8'b1000_0000, 2'b11, 3'b011, 5'd0);

        vecs[0]  = '{32'h2020C1B3, mk(8'b1000_0000, 2'b00, 3'b000, 5'd9),  1'b1}; // sh2add
        vecs[1]  = '{32'h087302BB, mk(8'b1000_0000, 2'b00, 3'b000, 5'd11), 1'b1}; // add.uw
        vecs[2]  = '{32'h00000000, ILL, 1'b1};
        vecs[3]  = '{32'h00500093, addi_exp, 1'b0};
        vecs[4]  = '{32'h402081B3, mk(8'b1000_0000, 2'b00, 3'b000, 5'd1),  1'b0}; // sub
        vecs[5]  = '{32'h0020F1B3, mk(8'b1000_0000, 2'b00, 3'b000, 5'd2),  1'b0}; // and
        vecs[6]  = '{32'h0020E1B3, mk(8'b1000_0000, 2'b00, 3'b000, 5'd3),  1'b0}; // or
        vecs[7]  = '{32'h0020A1B3, mk(8'b1000_0000, 2'b00, 3'b000, 5'd4),  1'b0}; // slt
        vecs[8]  = '{32'h0020C1B3, mk(8'b1000_0000, 2'b00, 3'b000, 5'd5),  1'b0}; // xor
        vecs[9]  = '{32'h002091B3, ILL, 1'b1};                                     // sll
        vecs[10] = '{32'h0080A283, mk(8'b1010_0000, 2'b01, 3'b000, 5'd0),  1'b0}; // lw
        vecs[11] = '{32'h0020A623, mk(8'b0110_0000, 2'b00, 3'b001, 5'd0),  1'b0}; // sw
        vecs[12] = '{32'h00208463, mk(8'b0001_0000, 2'b00, 3'b010, 5'd1),  1'b0}; // beq
        vecs[13] = '{32'h0020A463, ILL, 1'b1};                                     // branch f3=010
        vecs[14] = '{32'h010000EF, mk(8'b1000_1100, 2'b10, 3'b100, 5'd0),  1'b0}; // jal
        vecs[15] = '{32'h000100E7, mk(8'b1010_1100, 2'b10, 3'b000, 5'd0),  1'b0}; // jalr
        vecs[16] = '{32'h123452B7, lui_exp, 1'b0};                                 // lui
        vecs[17] = '{32'h002081BB, mk(8'b1000_0010, 2'b00, 3'b000, 5'd0),  1'b1}; // addw
        vecs[18] = '{32'h402081BB, mk(8'b1000_0010, 2'b00, 3'b000, 5'd1),  1'b1}; // subw
        vecs[19] = '{32'h0010809B, mk(8'b1010_0010, 2'b00, 3'b000, 5'd0),  1'b1}; // addiw
        vecs[20] = '{32'h0830919B, mk(8'b1010_0000, 2'b00, 3'b000, 5'd15), 1'b1}; // slli.uw
        vecs[21] = '{32'h2020A1BB, mk(8'b1000_0000, 2'b00, 3'b000, 5'd12), 1'b1}; // sh1add.uw
        vecs[22] = '{32'h2020E1B3, mk(8'b1000_0000, 2'b00, 3'b000, 5'd10), 1'b1}; // sh3add
        vecs[23] = '{32'h2020A1B3, mk(8'b1000_0000, 2'b00, 3'b000, 5'd8),  1'b1}; // sh1add
        vecs[24] = '{32'h002091BB, ILL, 1'b1};                                     // sllw
        vecs[25] = '{32'h0080B283, mk(8'b1010_0000, 2'b01, 3'b000, 5'd0),  1'b1}; // ld
        vecs[26] = '{32'h2020C1BB, mk(8'b1000_0000, 2'b00, 3'b000, 5'd13), 1'b1}; // sh2add.uw
        vecs[27] = '{32'h2020E1BB, mk(8'b1000_0000, 2'b00, 3'b000, 5'd14), 1'b1}; // sh3add.uw
        vecs[28] = '{32'h0C30919B, ILL, 1'b1};                                     // bad slli.uw imm
        vecs[29] = '{32'h022081B3, ILL, 1'b1};                                     // mul (no M)
        vecs[30] = '{32'h00000297, ILL, 1'b1};                                     // auipc

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check_cleared("reset");

        // Table stream at full throughput; every accept must show up next cycle
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 31; i++) begin
            set_in(vecs[i].instr, vecs[i].exp, vecs[i].ill_n, 64'h8000_0000_0000_1000 + 64'(i * 4));
            chk("stream_ready", in_ready, 1'b1);
            tick();
            chk("stream_valid", out_valid, 1'b1);
        end
        in_valid = 1'b0;
        drain("table_drain");
        chk("table_idle", out_valid, 1'b0);

        // Fill to TWO with EX stalled, then release and stream the rest
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_in(32'h00500093, addi_exp, 1'b0, 64'h100);
        tick();
        chk("hold1_pc", out_pc, 64'h100);
        set_in(32'h00500093, addi_exp, 1'b0, 64'h104);
        tick();
        chk("two_in_ready", in_ready, 1'b0);
        chk("two_out_valid", out_valid, 1'b1);
        chk("hold2_pc", out_pc, 64'h100);
        chk("hold2_instr", out_instr, 32'h00500093);
        out_ready = 1'b1;
        set_in(32'h00500093, addi_exp, 1'b0, 64'h108);
        n_acc    = 2;
        n_pop    = 0;
        last_pop = -1;
        for (int k = 0; k < 20 && (n_acc < 4 || sb.size() != 0); k++) begin
            acc = in_valid && in_ready;
            tick();
            if (popped) begin
                n_pop++;
                if (last_pop >= 0) chk("pop_gap", 64'(cyc - last_pop <= 2), 64'd1);
                last_pop = cyc;
            end
            if (acc) begin
                n_acc++;
                if (n_acc == 4) in_valid = 1'b0;
                else set_in(32'h00500093, addi_exp, 1'b0, in_pc + 64'd4);
            end
        end
        chk("stream4_pops", 64'(n_pop), 64'd4);
        chk("stream4_empty", 64'(sb.size()), 64'd0);

        // Flush while TWO, then a lone instruction afterwards
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_in(32'h00500093, addi_exp, 1'b0, 64'h200);
        tick();
        set_in(32'h00500093, addi_exp, 1'b0, 64'h204);
        tick();
        chk("flush_pre_two", in_ready, 1'b0);
        flush = 1'b1;
        set_in(32'h00500093, addi_exp, 1'b0, 64'h208);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        set_in(32'h123452B7, lui_exp, 1'b0, 64'h300);
        tick();
        in_valid = 1'b0;
        chk("post_flush_valid", out_valid, 1'b1);
        chk("post_flush_pc", out_pc, 64'h300);
        out_ready = 1'b1;
        tick();
        chk("post_flush_alone", out_valid, 1'b0);
        chk("post_flush_empty", 64'(sb.size()), 64'd0);

        // Flush in ONE with an input accepted in the same cycle: both dropped
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_in(32'h00500093, addi_exp, 1'b0, 64'h400);
        tick();
        flush = 1'b1;
        set_in(32'h00500093, addi_exp, 1'b0, 64'h404);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_one_valid", out_valid, 1'b0);
        tick();
        chk("flush_one_still_empty", out_valid, 1'b0);

        // Reset together with flush and in_valid while TWO
        in_valid = 1'b1;
        set_in(32'h2020C1B3, vecs[0].exp, 1'b1, 64'h500);
        tick();
        set_in(32'h2020C1B3, vecs[0].exp, 1'b1, 64'h504);
        tick();
        rst   = 1'b1;
        flush = 1'b1;
        tick();
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        check_cleared("rst_flush");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised successor to the combinational instruction decoder: decodes one 32-bit RISC-V instruction per cycle into execute-stage control fields, with valid/ready handshake, a 2-entry skid buffer and synchronous flush. Sits between IF/ID and EX, replacing the ID-stage decoder plus its pipeline register. Adds RV64 word ops, full Zba (including .uw forms), illegal-instruction flagging and compile-time ISA gating.

## Interface
- XLEN, 64: 32 or 64; width of PC path. XLEN=32 makes OP-32/OP-IMM-32 illegal.
- ZBA_EN, 1: 1 = decode Zba, 0 = Zba encodings flagged illegal.
- ALUC_W, 5: width of alu_control (≥5).
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all buffered entries (branch mispredict/trap)
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  registered; stage can accept
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  instruction PC
- out_valid  out  1  decoded entry valid
- out_ready  in  1  EX accepts
- out_pc / out_instr  out  XLEN / 32  passthrough
- reg_write, mem_write, alu_src, branch, jump, wd3_src, word_op, illegal  out  1 each
- result_src  out  2  00 ALU, 01 mem, 10 PC+4, 11 imm
- imm_src  out  3  000 I, 001 S, 010 B, 011 U, 100 J
- alu_control  out  ALUC_W  see Operation

## Operation
- Decode (combinational, then registered): OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI as before; add OP-32 (0111011), OP-IMM-32 (0011011).
- alu_control: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 XOR, 8 SH1ADD, 9 SH2ADD, 10 SH3ADD, 11 ADD.UW, 12 SH1ADD.UW, 13 SH2ADD.UW, 14 SH3ADD.UW, 15 SLLI.UW.
- Zba (ZBA_EN=1): OP funct7 0010000 funct3 010/100/110 → 8/9/10; OP-32 funct7 0000100 f3 000 → 11; OP-32 funct7 0010000 f3 010/100/110 → 12/13/14; OP-IMM-32 f3 001 imm[11:6]=000010 → 15, alu_src=1. All Zba: word_op=0.
- ADDW/SUBW/ADDIW: alu_control 0/1, word_op=1.
- illegal=1 for: unknown opcode, unlisted funct combination, Zba with ZBA_EN=0, any OP-32/OP-IMM-32 with XLEN=32. When illegal: reg_write=mem_write=branch=jump=0, others 0; out_valid still asserted (EX raises trap).
- Buffer FSM, states: EMPTY (out_valid=0), ONE (out reg valid), TWO (out reg + skid valid, in_ready=0).
  - EMPTY: accept → ONE.
  - ONE: accept & !pop → TWO (new entry to skid); pop & !accept → EMPTY; both → ONE (new entry to out reg).
  - TWO: pop → ONE (skid moves to out reg); no accept possible.
  - accept = in_valid & in_ready; pop = out_valid & out_ready.
- Order strictly preserved; no entry dropped or duplicated except by flush.
- flush: next state EMPTY; input accepted in flush cycle discarded; flush dominates accept/pop.

## Timing
- Latency: accepted in cycle N → out_valid in N+1 (EMPTY path). Throughput 1/cycle while out_ready=1.
- in_ready registered: 1 in EMPTY/ONE, 0 in TWO; no combinational in→out path on ready.
- out_* stable while out_valid & !out_ready.
- Reset: state EMPTY, out_valid=0, in_ready=1 from first cycle after reset, all payload outputs 0. rst mid-operation drops all entries identically to flush and has priority over flush.
- flush: out_valid=0, in_ready=1 in cycle after flush.

## Structure
- decode_pkg: opcode constants, ALU_* codes, IMM_* and RES_* codes, decoded-control struct typedef.
- Sub-module decode_comb: pure combinational instr → control struct (parameters XLEN, ZBA_EN). decode_stage holds FSM, out reg, skid reg.

## Test plan
- 0x2020C1B3 (sh2add x3,x1,x2), out_ready=1 → next cycle out_valid=1, alu_control=9, reg_write=1, alu_src=0, illegal=0.
- 0x087302BB (add.uw x5,x6,x7): ZBA_EN=1 → alu_control=11, word_op=0; ZBA_EN=0 → illegal=1, reg_write=0.
- 0x00000000 → illegal=1, all write/branch/jump 0, out_valid=1.
- Stream 4× 0x00500093 with out_ready low 2 cycles → state TWO, in_ready=0 one cycle after second accept; on release, 4 entries out in order, no gaps beyond one cycle.
- flush while TWO → next cycle out_valid=0, in_ready=1; following accepted instr appears alone.
- rst asserted with simultaneous flush and in_valid → cycle after: out_valid=0, in_ready=1, all outputs 0.
